alu_result_stage: RTL and testbench

Registered output stage directly downstream of the 64-bit bit-slice ALU. It captures each ALU result together with the carry information and derives zero, negative, carry and overflow flags. Results are held in a DEPTH-entry FIFO and handed to the consumer over a valid/ready handshake. This decouples the combinational ALU from the register-file writeback and status logic.

---
 rtl/alu_result_stage_if.sv | 32 +++
 rtl/alu_result_stage.sv | 126 ++++++++++++
 tb/tb_alu_result_stage.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/alu_result_stage_if.sv
// ALU result stage bus: producer-side push handshake and consumer-side pop handshake.
interface alu_result_stage_if #(
   parameter int unsigned WIDTH = 64
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       cntrl;
   logic [WIDTH-1:0] result;
   logic             carry_out;
   logic             carry_msb_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic             out_zero;
   logic             out_negative;
   logic             out_overflow;
   logic             out_carry;

   // Producer/consumer side of the stage
   modport master (
      output in_valid, cntrl, result, carry_out, carry_msb_in, out_ready,
      input  in_ready, out_valid, out_result, out_zero, out_negative,
             out_overflow, out_carry
   );

   // The stage itself
   modport slave (
      input  in_valid, cntrl, result, carry_out, carry_msb_in, out_ready,
      output in_ready, out_valid, out_result, out_zero, out_negative,
             out_overflow, out_carry
   );
endinterface

// File: rtl/alu_result_stage.sv
// Registered ALU output stage: derives zero/negative/carry/overflow flags at
// push time and buffers results in a DEPTH-entry FIFO with valid/ready on both
// sides. Optional sticky overflow bit enabled by ALU_STICKY_OVERFLOW_EN.
module alu_result_stage #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   alu_result_stage_if.slave      bus,
   input  logic                   clear_sticky,
   output logic [$clog2(DEPTH):0] count,
   output logic                   sticky_overflow
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef struct packed {
      logic [WIDTH-1:0] result;
      logic             zero;
      logic             negative;
      logic             overflow;
      logic             carry;
   } entry_t;

   entry_t        mem [DEPTH];
   entry_t        head_q;
   entry_t        head_n;
   entry_t        new_c;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr_n;
   logic [PW-1:0] rd_ptr_n;
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_n;
   logic          in_ready_q;
   logic          out_valid_q;
   logic          push_c;
   logic          pop_c;

   assign push_c = bus.in_valid && in_ready_q;
   assign pop_c  = out_valid_q && bus.out_ready;

   // Flag derivation for the incoming ALU result; unknown selects clear all flags
   always_comb begin
      new_c        = '0;
      new_c.result = bus.result;
      unique case (bus.cntrl)
         3'b000, 3'b100, 3'b101, 3'b110: begin
            new_c.zero     = (bus.result == '0);
            new_c.negative = bus.result[WIDTH-1];
         end
         3'b010, 3'b011: begin
            new_c.zero     = (bus.result == '0);
            new_c.negative = bus.result[WIDTH-1];
            new_c.carry    = bus.carry_out;
            new_c.overflow = bus.carry_out ^ bus.carry_msb_in;
         end
         default: ;
      endcase
   end

   // Next pointers, occupancy and head entry; a push landing at the new read
   // pointer bypasses storage so the head register is current one edge later
   always_comb begin
      wr_ptr_n = wr_ptr;
      rd_ptr_n = rd_ptr;
      count_n  = count_q;
      if (push_c) wr_ptr_n = wr_ptr + PW'(1);
      if (pop_c)  rd_ptr_n = rd_ptr + PW'(1);
      unique case ({push_c, pop_c})
         2'b10:   count_n = count_q + CW'(1);
         2'b01:   count_n = count_q - CW'(1);
         default: count_n = count_q;
      endcase
      if (push_c && (wr_ptr == rd_ptr_n)) head_n = new_c;
      else                                head_n = mem[rd_ptr_n];
   end

   // FIFO storage, pointers, occupancy and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_q     <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         head_q      <= '0;
      end else begin
         if (push_c) mem[wr_ptr] <= new_c;
         wr_ptr      <= wr_ptr_n;
         rd_ptr      <= rd_ptr_n;
         count_q     <= count_n;
         in_ready_q  <= (count_n < CW'(DEPTH));
         out_valid_q <= (count_n != '0);
         head_q      <= head_n;
      end
   end

   assign count            = count_q;
   assign bus.in_ready     = in_ready_q;
   assign bus.out_valid    = out_valid_q;
   assign bus.out_result   = head_q.result;
   assign bus.out_zero     = head_q.zero;
   assign bus.out_negative = head_q.negative;
   assign bus.out_overflow = head_q.overflow;
   assign bus.out_carry    = head_q.carry;

`ifdef ALU_STICKY_OVERFLOW_EN
   logic sticky_q;

   // Sticky overflow: a new overflow push wins over a simultaneous clear
   always_ff @(posedge clk) begin
      if (reset)                         sticky_q <= 1'b0;
      else if (push_c && new_c.overflow) sticky_q <= 1'b1;
      else if (clear_sticky)             sticky_q <= 1'b0;
   end

   assign sticky_overflow = sticky_q;
`else
   logic unused_clear_sticky;
   assign unused_clear_sticky = clear_sticky;
   assign sticky_overflow     = 1'b0;
`endif
endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage.
module tb_alu_result_stage;
   logic       clk;
   logic       reset;
   logic       clear_sticky;
   logic [2:0] count;
   logic       sticky_overflow;
   int         checks;
   int         failures;
   logic       sticky_exp;

   alu_result_stage_if #(.WIDTH(64)) bus ();

   alu_result_stage #(.WIDTH(64), .DEPTH(4)) dut (
      .clk             (clk),
      .reset           (reset),
      .bus             (bus),
      .clear_sticky    (clear_sticky),
      .count           (count),
      .sticky_overflow (sticky_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [2:0] c, input logic [63:0] r,
                        input logic co, input logic cmi);
      bus.in_valid     = v;
      bus.cntrl        = c;
      bus.result       = r;
      bus.carry_out    = co;
      bus.carry_msb_in = cmi;
   endtask

   initial begin
      checks = 0;
      failures = 0;
`ifdef ALU_STICKY_OVERFLOW_EN
      sticky_exp = 1'b1;
`else
      sticky_exp = 1'b0;
`endif
      reset = 1'b1;
      clear_sticky = 1'b0;
      bus.out_ready = 1'b0;
      drive(1'b0, 3'b000, 64'h0, 1'b0, 1'b0);
      tick();
      tick();
      reset = 1'b0;
      check("rst_count", 64'(count), 64'd0);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_out_result", bus.out_result, 64'd0);
      check("rst_sticky", 64'(sticky_overflow), 64'd0);

      // add with zero result, carry out, no overflow
      bus.out_ready = 1'b1;
      drive(1'b1, 3'b010, 64'h0, 1'b1, 1'b1);
      tick();
      check("add0_valid", 64'(bus.out_valid), 64'd1);
      check("add0_zero", 64'(bus.out_zero), 64'd1);
      check("add0_carry", 64'(bus.out_carry), 64'd1);
      check("add0_ovf", 64'(bus.out_overflow), 64'd0);
      check("add0_neg", 64'(bus.out_negative), 64'd0);

      // signed overflow into negative result; simultaneous push/pop at count 1
      drive(1'b1, 3'b010, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
      tick();
      check("ovf_neg", 64'(bus.out_negative), 64'd1);
      check("ovf_ovf", 64'(bus.out_overflow), 64'd1);
      check("ovf_carry", 64'(bus.out_carry), 64'd0);
      check("ovf_zero", 64'(bus.out_zero), 64'd0);
      check("ovf_count", 64'(count), 64'd1);
      check("ovf_sticky", 64'(sticky_overflow), 64'(sticky_exp));

      // overflow push coinciding with clear: set wins
      clear_sticky = 1'b1;
      tick();
      check("setclr_sticky", 64'(sticky_overflow), 64'(sticky_exp));

      // AND with zero result: carry/overflow suppressed, clear now takes effect
      drive(1'b1, 3'b100, 64'h0, 1'b1, 1'b0);
      tick();
      clear_sticky = 1'b0;
      check("and_zero", 64'(bus.out_zero), 64'd1);
      check("and_carry", 64'(bus.out_carry), 64'd0);
      check("and_ovf", 64'(bus.out_overflow), 64'd0);
      check("clr_sticky", 64'(sticky_overflow), 64'd0);

      // unlisted select: result stored, all flags zero
      drive(1'b1, 3'b001, 64'h8000_0000_0000_0000, 1'b1, 1'b0);
      tick();
      check("unl_result", bus.out_result, 64'h8000_0000_0000_0000);
      check("unl_neg", 64'(bus.out_negative), 64'd0);
      check("unl_ovf", 64'(bus.out_overflow), 64'd0);
      check("unl_carry", 64'(bus.out_carry), 64'd0);

      // drain
      drive(1'b0, 3'b000, 64'h0, 1'b0, 1'b0);
      tick();
      check("drain_count", 64'(count), 64'd0);
      check("drain_valid", 64'(bus.out_valid), 64'd0);

      // fill with consumer stalled: 5 offered, 4 accepted
      bus.out_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         drive(1'b1, 3'b000, 64'(i), 1'b0, 1'b0);
         tick();
         if (i == 4) begin
            check("full_count4", 64'(count), 64'd4);
            check("full_in_ready", 64'(bus.in_ready), 64'd0);
         end
      end
      check("full_count5", 64'(count), 64'd4);
      check("full_head", bus.out_result, 64'd1);

      // full: push refused while pop happens
      bus.out_ready = 1'b1;
      drive(1'b1, 3'b000, 64'd6, 1'b0, 1'b0);
      tick();
      check("fullpop_count", 64'(count), 64'd3);
      check("fullpop_head", bus.out_result, 64'd2);
      check("fullpop_in_ready", 64'(bus.in_ready), 64'd1);

      // next push accepted into wrapped slot; head stable while stalled
      bus.out_ready = 1'b0;
      tick();
      check("wrap_count", 64'(count), 64'd4);
      check("stall_head", bus.out_result, 64'd2);

      // pop remaining in order across the wrap
      drive(1'b0, 3'b000, 64'h0, 1'b0, 1'b0);
      bus.out_ready = 1'b1;
      tick();
      check("pop_3", bus.out_result, 64'd3);
      tick();
      check("pop_4", bus.out_result, 64'd4);
      tick();
      check("pop_6", bus.out_result, 64'd6);
      check("pop_count", 64'(count), 64'd1);

      // build count=3 with an overflow entry, then reset mid-stream
      bus.out_ready = 1'b0;
      drive(1'b1, 3'b000, 64'd8, 1'b0, 1'b0);
      tick();
      drive(1'b1, 3'b011, 64'd9, 1'b1, 1'b0);
      tick();
      check("pre_rst_count", 64'(count), 64'd3);
      check("pre_rst_sticky", 64'(sticky_overflow), 64'(sticky_exp));
      check("pre_rst_head", bus.out_result, 64'd6);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      drive(1'b0, 3'b000, 64'h0, 1'b0, 1'b0);
      check("mid_rst_count", 64'(count), 64'd0);
      check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
      check("mid_rst_result", bus.out_result, 64'd0);
      check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("mid_rst_sticky", 64'(sticky_overflow), 64'd0);

      // post-reset push appears after one edge
      drive(1'b1, 3'b000, 64'd10, 1'b0, 1'b0);
      tick();
      drive(1'b0, 3'b000, 64'h0, 1'b0, 1'b0);
      check("post_rst_head", bus.out_result, 64'd10);
      check("post_rst_count", 64'(count), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
